uart_baud_timer: RTL and testbench

Parametrised bit-period timer for the UART transmit and receive engines. It generates a one-cycle `btu` strobe at the end of every bit period of a programmable divisor and counts bits within a frame. It raises `frame_done` after a programmable number of bits, and can optionally shorten the first period to half a bit so the receiver samples at bit centres. It sits between the UART control FSMs (which drive `doit`) and their shift registers (which consume `btu`).

---
 rtl/uart_baud_timer_if.sv | 23 ++
 rtl/uart_baud_timer.sv | 114 +++++++++++
 tb/tb_uart_baud_timer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_baud_timer_if.sv
// Bit-timer handshake bundle between the UART control FSMs (master) and uart_baud_timer (slave).
interface uart_baud_timer_if #(
  parameter int CNT_W = 19,
  parameter int BIT_W = 4
);
  logic             doit;
  logic [CNT_W-1:0] k;
  logic [BIT_W-1:0] nbits;
  logic             btu;
  logic [BIT_W-1:0] bit_idx;
  logic             frame_done;
  logic             busy;

  modport master (
    output doit, k, nbits,
    input  btu, bit_idx, frame_done, busy
  );

  modport slave (
    input  doit, k, nbits,
    output btu, bit_idx, frame_done, busy
  );
endinterface

// File: rtl/uart_baud_timer.sv
// UART bit-period timer: btu strobe every k+1 clocks, bit counting, frame_done on the last bit.
// Define UART_BAUD_HALF_START_EN to shorten the first period to floor(k/2)+1 for mid-bit sampling.
//
// state     | meaning
// IDLE      | waiting for doit, counters cleared, k/nbits latched on exit
// FIRST     | half-length first bit period (UART_BAUD_HALF_START_EN only)
// RUN       | full bit periods, btu at cnt == k_lat
// DONE_WAIT | frame finished, holds off re-trigger until doit drops
module uart_baud_timer #(
  parameter int CNT_W = 19,
  parameter int BIT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_baud_timer_if.slave   bus
);

`ifdef UART_BAUD_HALF_START_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT, FIRST} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE_WAIT} state_t;
`endif

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] k_lat, k_lat_n;
  logic [BIT_W-1:0] nb_lat, nb_lat_n;
  logic [BIT_W-1:0] bit_idx, bit_idx_n;
  logic [CNT_W-1:0] tc;
  logic             timing;
  logic             btu;
  logic             frame_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      k_lat   <= '0;
      nb_lat  <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      k_lat   <= k_lat_n;
      nb_lat  <= nb_lat_n;
      bit_idx <= bit_idx_n;
    end
  end

  // Strobes decode registers only, so they stay valid in the cycle doit falls.
  always_comb begin
    tc     = k_lat;
    timing = (state == RUN);
`ifdef UART_BAUD_HALF_START_EN
    if (state == FIRST) begin
      tc     = k_lat >> 1;
      timing = 1'b1;
    end
`endif
    btu        = timing && (cnt == tc);
    frame_done = btu && (nb_lat != '0) && (bit_idx == nb_lat - BIT_W'(1));
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    k_lat_n   = k_lat;
    nb_lat_n  = nb_lat;
    bit_idx_n = bit_idx;
    case (state)
      IDLE: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (bus.doit) begin
          k_lat_n  = bus.k;
          nb_lat_n = bus.nbits;
`ifdef UART_BAUD_HALF_START_EN
          state_n  = FIRST;
`else
          state_n  = RUN;
`endif
        end
      end
      DONE_WAIT: begin
        cnt_n     = '0;
        bit_idx_n = '0;
        if (!bus.doit) state_n = IDLE;
      end
      default: begin
        if (!bus.doit) begin
          state_n   = IDLE;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else if (frame_done) begin
          state_n   = DONE_WAIT;
          cnt_n     = '0;
          bit_idx_n = '0;
        end else if (btu) begin
          cnt_n     = '0;
          bit_idx_n = bit_idx + BIT_W'(1);
          state_n   = RUN;
        end else begin
          cnt_n     = cnt + CNT_W'(1);
        end
      end
    endcase
  end

  assign bus.btu        = btu;
  assign bus.frame_done = frame_done;
  assign bus.bit_idx    = bit_idx;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_baud_timer.sv
// Directed bench for uart_baud_timer; expectations adapt to UART_BAUD_HALF_START_EN.
module tb_uart_baud_timer;
  localparam int CNT_W = 19;
  localparam int BIT_W = 4;
`ifdef UART_BAUD_HALF_START_EN
  localparam bit HALF = 1'b1;
`else
  localparam bit HALF = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  uart_baud_timer_if #(.CNT_W(CNT_W), .BIT_W(BIT_W)) bus ();

  uart_baud_timer #(.CNT_W(CNT_W), .BIT_W(BIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame per record: k at start, k2 applied mid-frame, doit held for hold cycles.
  // first/fd are cycle offsets after E0 (-1 = never), for the plain and half-start builds.
  typedef struct {
    int k;
    int k2;
    int nb;
    int hold;
    int first_nm;
    int first_hm;
    int btus;
    int fd_nm;
    int fd_hm;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int first;
    int btus;
    int fdc;
    int fdn;
    int badbits;
    int busylow;
    first = -1; btus = 0; fdc = -1; fdn = 0; badbits = 0; busylow = 0;
    @(negedge clk);
    bus.k     = CNT_W'(v.k);
    bus.nbits = BIT_W'(v.nb);
    bus.doit  = 1'b1;
    for (int c = 0; c < v.hold; c++) begin
      @(negedge clk);
      if (!bus.busy) busylow++;
      if (bus.btu) begin
        if (first < 0) first = c;
        if (bus.bit_idx != BIT_W'(btus)) badbits++;
        btus++;
      end
      if (bus.frame_done) begin
        fdc = c;
        fdn++;
      end
      if (c == 4) bus.k = CNT_W'(v.k2);
      if (c == v.hold - 1) bus.doit = 1'b0;
    end
    check($sformatf("v%0d first_btu", idx), first, HALF ? v.first_hm : v.first_nm);
    check($sformatf("v%0d btu_count", idx), btus, v.btus);
    check($sformatf("v%0d fd_cycle", idx), fdc, HALF ? v.fd_hm : v.fd_nm);
    check($sformatf("v%0d fd_count", idx), fdn, (v.fd_nm >= 0) ? 1 : 0);
    check($sformatf("v%0d bit_idx_seq_errs", idx), badbits, 0);
    check($sformatf("v%0d busy_low_cycles", idx), busylow, 0);
    @(negedge clk);
    check($sformatf("v%0d post_busy", idx), int'(bus.busy), 0);
    check($sformatf("v%0d post_bit_idx", idx), int'(bus.bit_idx), 0);
  endtask

  initial begin
    int btus;
    int fdn;
    int first;
    n_cmp = 0;
    n_bad = 0;
    vecs[0] = '{k:9, k2:9, nb:10, hold:120, first_nm:9, first_hm:4, btus:10, fd_nm:99, fd_hm:94};
    vecs[1] = '{k:9, k2:3, nb:3,  hold:40,  first_nm:9, first_hm:4, btus:3,  fd_nm:29, fd_hm:24};
    vecs[2] = '{k:3, k2:3, nb:2,  hold:12,  first_nm:3, first_hm:1, btus:2,  fd_nm:7,  fd_hm:5};
    vecs[3] = '{k:0, k2:0, nb:0,  hold:40,  first_nm:0, first_hm:0, btus:40, fd_nm:-1, fd_hm:-1};
    vecs[4] = '{k:1, k2:1, nb:4,  hold:8,   first_nm:1, first_hm:0, btus:4,  fd_nm:7,  fd_hm:6};
    vecs[5] = '{k:4, k2:4, nb:0,  hold:20,  first_nm:4, first_hm:2, btus:4,  fd_nm:-1, fd_hm:-1};

    rst       = 1'b1;
    bus.doit  = 1'b0;
    bus.k     = '0;
    bus.nbits = '0;
    repeat (3) @(negedge clk);
    check("reset btu", int'(bus.btu), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset bit_idx", int'(bus.bit_idx), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", int'(bus.busy), 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort: doit drops 3 cycles after the 2nd btu (plain build timing).
    @(negedge clk);
    bus.k = CNT_W'(9); bus.nbits = BIT_W'(8); bus.doit = 1'b1;
    btus = 0; fdn = 0;
    for (int c = 0; c < 23; c++) begin
      @(negedge clk);
      if (bus.btu) btus++;
      if (bus.frame_done) fdn++;
      if (c == 22) begin
        check("abort bit_idx_before", int'(bus.bit_idx), 2);
        bus.doit = 1'b0;
      end
    end
    check("abort btus_before", btus, 2);
    @(negedge clk);
    check("abort busy", int'(bus.busy), 0);
    check("abort bit_idx", int'(bus.bit_idx), 0);
    btus = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.btu) btus++;
      if (bus.frame_done) fdn++;
    end
    check("abort btus_after", btus, 0);
    check("abort frame_done", fdn, 0);

    // Asynchronous reset mid-RUN, then restart with doit held high.
    @(negedge clk);
    bus.k = CNT_W'(9); bus.nbits = BIT_W'(10); bus.doit = 1'b1;
    repeat (12) @(negedge clk);
    check("pre_rst bit_idx", int'(bus.bit_idx), 1);
    #2 rst = 1'b1;
    #1;
    check("rst async busy", int'(bus.busy), 0);
    check("rst async bit_idx", int'(bus.bit_idx), 0);
    check("rst async btu", int'(bus.btu), 0);
    check("rst async frame_done", int'(bus.frame_done), 0);
    @(negedge clk);
    rst = 1'b0;
    first = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) check("restart busy", int'(bus.busy), 1);
      if (bus.btu && first < 0) first = c;
    end
    check("restart first_btu", first, HALF ? 4 : 9);
    bus.doit = 1'b0;
    @(negedge clk);
    check("restart end busy", int'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
